tsc_multi_capture: RTL and testbench

- Parametrised triggered-streaming-capture block; next generation of the single-channel trigger/ring-buffer capture unit.
- Pulls samples from an ADC over a req/rdy handshake and keeps a pre-trigger history in a ring buffer.
- Detects a trigger with selectable mode and a runtime threshold, then captures a fixed post-trigger window and flags trd.
- On sbf it serialises the window oldest-first onto sd with start/stop framing, then pulses cd.

---
 rtl/tsc_pkg.sv | 19 +
 rtl/tsc_serializer.sv | 42 ++++
 rtl/tsc_multi_capture.sv | 192 +++++++++++++++++++
 tb/tb_tsc_multi_capture.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsc_pkg.sv
// Shared types for the triggered streaming capture block: FSM states and trigger modes.
package tsc_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RECORD = 3'd1,
      POST   = 3'd2,
      DONE   = 3'd3,
      SEND   = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      TRIG_ABOVE = 2'd0,
      TRIG_BELOW = 2'd1,
      TRIG_RISE  = 2'd2,
      TRIG_FORCE = 2'd3
   } trig_mode_e;

endpackage

// File: rtl/tsc_serializer.sv
// Frames one DATA_W word as start bit, LSB-first data, stop bit; sd idles high.
module tsc_serializer #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   output logic              sd,
   output logic              byte_done
);
   localparam int unsigned FRAME_W = DATA_W + 2;
   localparam int unsigned CNT_W   = $clog2(FRAME_W);

   logic [FRAME_W-1:0] frame_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               active_q;

   // A load on the final bit cycle starts the next frame back-to-back.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_q  <= '1;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (load) begin
         frame_q  <= {1'b1, data, 1'b0};
         cnt_q    <= CNT_W'(FRAME_W - 1);
         active_q <= 1'b1;
      end else if (active_q) begin
         frame_q <= {1'b1, frame_q[FRAME_W-1:1]};
         if (cnt_q == '0) begin
            active_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

   assign sd        = frame_q[0];
   assign byte_done = active_q && (cnt_q == '0);

endmodule

// File: rtl/tsc_multi_capture.sv
// Triggered capture: ring-buffered ADC history, post-trigger window, framed serial readout.
module tsc_multi_capture
   import tsc_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 32,
   parameter int unsigned POST_TRIG = 16,
   parameter int unsigned TS_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              sbf,
   input  logic [DATA_W-1:0] thresh,
   input  logic [1:0]        trig_mode,
   output logic              adc_req,
   input  logic              adc_rdy,
   input  logic [DATA_W-1:0] adc_dat,
   output logic              trd,
   output logic              cd,
   output logic              sd,
   output logic              busy,
   output logic [TS_W-1:0]   trig_time
);
   localparam int unsigned      PTR_W     = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] POST_LAST = PTR_W'(POST_TRIG - 1);
   localparam logic [PTR_W:0]   FULL      = (PTR_W+1)'(DEPTH);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, send_ptr_q, post_cnt_q, rd_start;
   logic [PTR_W:0]    count_q, remaining_q;
   logic [TS_W-1:0]   timer_q, trig_time_q;
   logic [DATA_W-1:0] prev_q;
   logic              prev_valid_q, trd_q, cd_q;
   logic              hit, arm, wr_en, trig_hit, post_done, send_go, send_next, send_end;
   logic              ser_load, byte_done;
   logic [DATA_W-1:0] ser_data;

   assign rd_start = wr_ptr_q - count_q[PTR_W-1:0];

   always_comb begin
      hit = 1'b0;
      case (trig_mode_e'(trig_mode))
         TRIG_ABOVE: hit = adc_dat > thresh;
         TRIG_BELOW: hit = adc_dat < thresh;
         TRIG_RISE:  hit = prev_valid_q && (prev_q <= thresh) && (adc_dat > thresh);
         TRIG_FORCE: hit = 1'b1;
         default:    hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      adc_req   = 1'b0;
      arm       = 1'b0;
      wr_en     = 1'b0;
      trig_hit  = 1'b0;
      post_done = 1'b0;
      send_go   = 1'b0;
      send_next = 1'b0;
      send_end  = 1'b0;
      ser_load  = 1'b0;
      ser_data  = mem[send_ptr_q + PTR_W'(1)];
      case (state_q)
         IDLE: begin
            if (start) begin
               arm     = 1'b1;
               state_d = RECORD;
            end
         end
         RECORD: begin
            adc_req = 1'b1;
            if (adc_rdy) begin
               wr_en = 1'b1;
               if (hit) begin
                  trig_hit = 1'b1;
                  state_d  = POST;
               end
            end
         end
         POST: begin
            adc_req = 1'b1;
            if (adc_rdy) begin
               wr_en = 1'b1;
               if (post_cnt_q == POST_LAST) begin
                  post_done = 1'b1;
                  state_d   = DONE;
               end
            end
         end
         DONE: begin
            // sbf takes priority over start
            if (sbf) begin
               send_go  = 1'b1;
               ser_load = 1'b1;
               ser_data = mem[rd_start];
               state_d  = SEND;
            end else if (start) begin
               arm     = 1'b1;
               state_d = RECORD;
            end
         end
         SEND: begin
            if (byte_done) begin
               if (remaining_q == (PTR_W+1)'(1)) begin
                  send_end = 1'b1;
                  state_d  = IDLE;
               end else begin
                  send_next = 1'b1;
                  ser_load  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Buffer contents survive reset; only the pointers are cleared.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= adc_dat;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q     <= '0;
         count_q      <= '0;
         timer_q      <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         post_cnt_q   <= '0;
         trig_time_q  <= '0;
         trd_q        <= 1'b0;
         cd_q         <= 1'b0;
         send_ptr_q   <= '0;
         remaining_q  <= '0;
      end else begin
         cd_q <= send_end;
         if (arm) begin
            wr_ptr_q     <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            trd_q        <= 1'b0;
            prev_valid_q <= 1'b0;
         end
         if (wr_en) begin
            wr_ptr_q     <= wr_ptr_q + PTR_W'(1);
            timer_q      <= timer_q + TS_W'(1);
            prev_q       <= adc_dat;
            prev_valid_q <= 1'b1;
            if (count_q != FULL) count_q <= count_q + (PTR_W+1)'(1);
         end
         if (trig_hit) begin
            trig_time_q <= timer_q;
            post_cnt_q  <= '0;
         end
         if (state_q == POST && wr_en) post_cnt_q <= post_cnt_q + PTR_W'(1);
         if (post_done) trd_q <= 1'b1;
         if (send_go) begin
            trd_q       <= 1'b0;
            send_ptr_q  <= rd_start;
            remaining_q <= count_q;
         end
         if (send_next) begin
            send_ptr_q  <= send_ptr_q + PTR_W'(1);
            remaining_q <= remaining_q - (PTR_W+1)'(1);
         end
      end
   end

   tsc_serializer #(
      .DATA_W (DATA_W)
   ) u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (ser_load),
      .data      (ser_data),
      .sd        (sd),
      .byte_done (byte_done)
   );

   assign trd       = trd_q;
   assign cd        = cd_q;
   assign trig_time = trig_time_q;
   assign busy      = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_tsc_multi_capture.sv
// Randomised bench for tsc_multi_capture against a sample-list reference model.
module tb_tsc_multi_capture;
   localparam int DATA_W    = 8;
   localparam int DEPTH     = 32;
   localparam int POST_TRIG = 16;
   localparam int TS_W      = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              sbf = 1'b0;
   logic [DATA_W-1:0] thresh = '0;
   logic [1:0]        trig_mode = '0;
   logic              adc_rdy = 1'b0;
   logic [DATA_W-1:0] adc_dat = '0;
   logic              adc_req, trd, cd, sd, busy;
   logic [TS_W-1:0]   trig_time;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] samples[$];
   logic [7:0] exp_bytes[$];
   int         exp_trig;

   always #5 clk = ~clk;

   tsc_multi_capture #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .POST_TRIG (POST_TRIG),
      .TS_W      (TS_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sbf       (sbf),
      .thresh    (thresh),
      .trig_mode (trig_mode),
      .adc_req   (adc_req),
      .adc_rdy   (adc_rdy),
      .adc_dat   (adc_dat),
      .trd       (trd),
      .cd        (cd),
      .sd        (sd),
      .busy      (busy),
      .trig_time (trig_time)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Index of the first accepted sample that satisfies the trigger rule, -1 if none.
   function automatic int ref_trig(input logic [1:0] mode, input logic [7:0] th);
      for (int i = 0; i < samples.size(); i++) begin
         case (mode)
            2'd0: if (samples[i] > th) return i;
            2'd1: if (samples[i] < th) return i;
            2'd2: if (i > 0 && samples[i-1] <= th && samples[i] > th) return i;
            default: return i;
         endcase
      end
      return -1;
   endfunction

   task automatic random_samples(input int n);
      samples.delete();
      for (int i = 0; i < n; i++) samples.push_back(8'($urandom_range(0, 255)));
   endtask

   // Expected readout: the newest min(n, DEPTH) accepted samples, oldest first.
   task automatic build_expected;
      int n, first;
      n = exp_trig + 1 + POST_TRIG;
      first = (n > DEPTH) ? n - DEPTH : 0;
      exp_bytes.delete();
      for (int i = first; i < n; i++) exp_bytes.push_back(samples[i]);
   endtask

   // rdy_style: 0 always ready, 1 every other cycle, 2 random
   task automatic run_capture(input logic [1:0] mode, input logic [7:0] th, input int rdy_style);
      int  idx, cyc;
      logic rdy, acc;
      exp_trig  = ref_trig(mode, th);
      trig_mode = mode;
      thresh    = th;
      start     = 1'b1;
      tick;
      start = 1'b0;
      n_checks++;
      if (trd !== 1'b0 || adc_req !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL arm: trd=%b adc_req=%b busy=%b want 0 1 1", trd, adc_req, busy);
      end
      idx = 0;
      cyc = 0;
      while (trd !== 1'b1 && cyc < 3000) begin
         case (rdy_style)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         adc_rdy = rdy;
         adc_dat = (idx < samples.size()) ? samples[idx] : 8'h00;
         acc = adc_req && rdy;
         tick;
         if (acc) idx++;
         cyc++;
      end
      adc_rdy = 1'b0;
      n_checks++;
      if (trd !== 1'b1) begin
         n_fail++;
         $display("FAIL trd_timeout: trd=%b want 1", trd);
      end
      n_checks++;
      if (idx != exp_trig + 1 + POST_TRIG) begin
         n_fail++;
         $display("FAIL accepted_count: got %0d want %0d", idx, exp_trig + 1 + POST_TRIG);
      end
      n_checks++;
      if (trig_time !== TS_W'(exp_trig)) begin
         n_fail++;
         $display("FAIL trig_time: got %0d want %0d", trig_time, exp_trig);
      end
      n_checks++;
      if (adc_req !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL done_state: adc_req=%b busy=%b want 0 0", adc_req, busy);
      end
      build_expected();
   endtask

   // with_start also asserts start with sbf and once more mid-frame; both must be ignored.
   task automatic run_send(input bit with_start);
      int         cd_seen;
      logic [9:0] frame;
      sbf   = 1'b1;
      start = with_start;
      tick;
      sbf   = 1'b0;
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || trd !== 1'b0 || adc_req !== 1'b0) begin
         n_fail++;
         $display("FAIL send_entry: busy=%b trd=%b adc_req=%b want 1 0 0", busy, trd, adc_req);
      end
      cd_seen = 0;
      for (int b = 0; b < exp_bytes.size(); b++) begin
         frame = '0;
         for (int k = 0; k < 10; k++) begin
            frame[k] = sd;
            if (cd === 1'b1) cd_seen++;
            start = (with_start && b == 1 && k == 3);
            tick;
         end
         n_checks++;
         if (frame !== {1'b1, exp_bytes[b], 1'b0}) begin
            n_fail++;
            $display("FAIL frame[%0d]: got %b want %b", b, frame, {1'b1, exp_bytes[b], 1'b0});
         end
      end
      start = 1'b0;
      n_checks++;
      if (cd !== 1'b1 || cd_seen != 0) begin
         n_fail++;
         $display("FAIL cd_timing: cd=%b early_pulses=%0d want 1 0", cd, cd_seen);
      end
      tick;
      n_checks++;
      if (cd !== 1'b0 || sd !== 1'b1 || busy !== 1'b0 || adc_req !== 1'b0) begin
         n_fail++;
         $display("FAIL send_end: cd=%b sd=%b busy=%b adc_req=%b want 0 1 0 0",
                  cd, sd, busy, adc_req);
      end
   endtask

   task automatic test_reset;
      repeat (3) tick;
      n_checks++;
      if (adc_req !== 1'b0 || trd !== 1'b0 || cd !== 1'b0 || sd !== 1'b1 || busy !== 1'b0 ||
          trig_time !== '0) begin
         n_fail++;
         $display("FAIL reset: req=%b trd=%b cd=%b sd=%b busy=%b tt=%0h want 0 0 0 1 0 0",
                  adc_req, trd, cd, sd, busy, trig_time);
      end
      reset = 1'b1;
      sbf   = 1'b1;
      tick;
      sbf = 1'b0;
      tick;
      n_checks++;
      if (busy !== 1'b0 || sd !== 1'b1 || cd !== 1'b0) begin
         n_fail++;
         $display("FAIL sbf_in_idle: busy=%b sd=%b cd=%b want 0 1 0", busy, sd, cd);
      end
   endtask

   task automatic test_ramp;
      samples.delete();
      for (int i = 0; i < 256; i++) samples.push_back(8'(i));
      run_capture(2'd0, 8'hD5, 0);
      n_checks++;
      if (exp_bytes.size() != DEPTH || exp_bytes[0] !== 8'hC7 || exp_bytes[DEPTH-1] !== 8'hE6)
      begin
         n_fail++;
         $display("FAIL ramp_model: size=%0d first=%h last=%h want 32 c7 e6",
                  exp_bytes.size(), exp_bytes[0], exp_bytes[exp_bytes.size()-1]);
      end
      run_send(1'b0);
   endtask

   task automatic test_rise;
      random_samples(40);
      samples[0] = 8'h90;
      samples[1] = 8'h70;
      samples[2] = 8'h85;
      run_capture(2'd2, 8'h80, 0);
      n_checks++;
      if (exp_trig != 2 || exp_bytes.size() != 19) begin
         n_fail++;
         $display("FAIL rise_model: trig=%0d count=%0d want 2 19", exp_trig, exp_bytes.size());
      end
      run_send(1'b0);
   endtask

   task automatic test_toggle_rdy;
      random_samples(80);
      for (int i = 0; i < 10; i++) samples[i] = 8'h40 + 8'(i);
      run_capture(2'd1, 8'h20, 1);
      run_send(1'b0);
   endtask

   task automatic test_random;
      logic [1:0] mode;
      logic [7:0] th;
      int         t;
      for (int it = 0; it < 4; it++) begin
         random_samples(60);
         mode = 2'($urandom_range(0, 3));
         th   = 8'($urandom_range(8'h40, 8'hBF));
         t    = ref_trig(mode, th);
         if (t < 0 || t + 1 + POST_TRIG > 60) mode = 2'd3;
         run_capture(mode, th, 2);
         run_send(1'b0);
      end
   endtask

   task automatic test_back_to_back;
      random_samples(50);
      run_capture(2'd0, 8'h10, 0);
      random_samples(50);
      run_capture(2'd3, 8'h00, 2);
      run_send(1'b1);
   endtask

   task automatic test_reset_mid_send;
      logic bad;
      random_samples(40);
      run_capture(2'd3, 8'h00, 0);
      sbf = 1'b1;
      tick;
      sbf = 1'b0;
      repeat (24) tick;
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (sd !== 1'b1 || trd !== 1'b0 || adc_req !== 1'b0 || busy !== 1'b0 || cd !== 1'b0 ||
          trig_time !== '0) begin
         n_fail++;
         $display("FAIL async_reset: sd=%b trd=%b req=%b busy=%b cd=%b tt=%0h want 1 0 0 0 0 0",
                  sd, trd, adc_req, busy, cd, trig_time);
      end
      tick;
      reset = 1'b1;
      sbf   = 1'b1;
      tick;
      sbf = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (sd !== 1'b1 || busy !== 1'b0 || trd !== 1'b0 || cd !== 1'b0) bad = 1'b1;
         tick;
      end
      n_checks++;
      if (bad !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: got disturbance=%b want 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_rise();
      test_toggle_rdy();
      test_random();
      test_back_to_back();
      test_reset_mid_send();
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
